inpkt_parser: RTL and testbench

- Sits between the input FIFO read side and the application, in the packet-communication clock domain.
- Consumes the 8-bit host byte stream and validates an 8-byte header.
- Forwards payload bytes through a valid/ready handshake and checks a 16-bit trailer checksum.
- Reports packet completion and sticky error flags for the status path read by the host.

---
 rtl/inpkt_parser.sv | 191 +++++++++++++++++++
 tb/tb_inpkt_parser.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inpkt_parser.sv
// inpkt_parser: input-FIFO packet parser.
// Validates an 8-byte header, forwards the payload over a valid/ready
// handshake and, when INPKT_CKSUM_EN is defined, checks a 16-bit
// little-endian trailer checksum. Error flags in status are sticky.
// Build option: INPKT_CKSUM_EN (undefined by default: no trailer, no checksum).
module inpkt_parser #(
  parameter logic [7:0]  VERSION   = 8'd2,
  parameter logic [7:0]  TYPE_MASK = 8'b0000_0110,
  parameter logic [23:0] MAX_LEN   = 24'd16384
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [7:0]  din,
  input  logic        empty,
  output logic        rd_en,
  output logic        hdr_valid,
  output logic [7:0]  pkt_type,
  output logic [15:0] pkt_id,
  output logic [23:0] pkt_len,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last,
  output logic        pkt_done,
  output logic [7:0]  status
);

  typedef enum logic [1:0] {HDR, PAYLOAD, CKSUM, ERROR} state_t;

  state_t      state;
  logic [23:0] cnt;
  logic [7:0]  ver_byte;
  logic        err_version;
  logic        err_type;
  logic        err_len;
  logic        err_cksum;
  logic        take;
  logic        bad_ver;
  logic        bad_type;
  logic        bad_len;
  logic [23:0] cnt_inc;

`ifdef INPKT_CKSUM_EN
  logic [15:0] acc;
  logic [7:0]  ck_lo;
  logic        done_pend;
`else
  // Without a trailer the packet completes the moment the last byte is taken.
  assign err_cksum = 1'b0;
  assign pkt_done  = dout_valid && dout_ready && dout_last;
`endif

  assign status  = {4'b0000, err_cksum, err_len, err_type, err_version};
  assign take    = rd_en && !empty;
  assign cnt_inc = cnt + 24'd1;

  // Header checks, evaluated while byte 7 (on din) is being consumed.
  assign bad_ver  = (ver_byte != VERSION);
  assign bad_type = (pkt_type > 8'd7) || !TYPE_MASK[pkt_type[2:0]];
  assign bad_len  = (pkt_len == 24'd0) || (pkt_len > MAX_LEN) || (din != 8'h00);

  // FIFO read strobe: payload reads back-pressure on the output register.
  always_comb begin
    rd_en = 1'b0;
    if (RESET_N) begin
      case (state)
        HDR, CKSUM: rd_en = !empty;
        PAYLOAD:    rd_en = !empty && (!dout_valid || dout_ready);
        default:    rd_en = 1'b0;
      endcase
    end
  end

  // Parser FSM with registered outputs, output holding register and checksum.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= HDR;
      cnt         <= 24'd0;
      ver_byte    <= 8'h00;
      hdr_valid   <= 1'b0;
      pkt_type    <= 8'h00;
      pkt_id      <= 16'h0000;
      pkt_len     <= 24'd0;
      dout        <= 8'h00;
      dout_valid  <= 1'b0;
      dout_last   <= 1'b0;
      err_version <= 1'b0;
      err_type    <= 1'b0;
      err_len     <= 1'b0;
`ifdef INPKT_CKSUM_EN
      err_cksum   <= 1'b0;
      pkt_done    <= 1'b0;
      acc         <= 16'h0000;
      ck_lo       <= 8'h00;
      done_pend   <= 1'b0;
`endif
    end else begin
      hdr_valid <= 1'b0;
      // A taken output byte frees the register unless a new byte loads below.
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
`ifdef INPKT_CKSUM_EN
      pkt_done <= 1'b0;
      // Completion waits for the final payload byte to leave.
      if (done_pend && dout_valid && dout_ready) begin
        pkt_done  <= 1'b1;
        done_pend <= 1'b0;
      end
`endif
      case (state)
        HDR: begin
          if (take) begin
            cnt <= cnt_inc;
`ifdef INPKT_CKSUM_EN
            acc <= (cnt == 24'd0) ? {8'h00, din} : acc + {8'h00, din};
`endif
            case (cnt[2:0])
              3'd0: ver_byte       <= din;
              3'd1: pkt_type       <= din;
              3'd2: pkt_id[7:0]    <= din;
              3'd3: pkt_id[15:8]   <= din;
              3'd4: pkt_len[7:0]   <= din;
              3'd5: pkt_len[15:8]  <= din;
              3'd6: pkt_len[23:16] <= din;
              default: begin
                cnt         <= 24'd0;
                err_version <= err_version | bad_ver;
                err_type    <= err_type | bad_type;
                err_len     <= err_len | bad_len;
                if (bad_ver || bad_type || bad_len) begin
                  state <= ERROR;
                end else begin
                  hdr_valid <= 1'b1;
                  state     <= PAYLOAD;
                end
              end
            endcase
          end
        end
        PAYLOAD: begin
          if (take) begin
            dout       <= din;
            dout_valid <= 1'b1;
            dout_last  <= (cnt_inc == pkt_len);
`ifdef INPKT_CKSUM_EN
            acc <= acc + {8'h00, din};
`endif
            if (cnt_inc == pkt_len) begin
              cnt <= 24'd0;
`ifdef INPKT_CKSUM_EN
              state <= CKSUM;
`else
              state <= HDR;
`endif
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
`ifdef INPKT_CKSUM_EN
        CKSUM: begin
          if (take) begin
            if (cnt == 24'd0) begin
              ck_lo <= din;
              cnt   <= 24'd1;
            end else begin
              cnt <= 24'd0;
              if ({din, ck_lo} == acc) begin
                state <= HDR;
                if (dout_valid && !dout_ready) done_pend <= 1'b1;
                else                          pkt_done  <= 1'b1;
              end else begin
                err_cksum <= 1'b1;
                state     <= ERROR;
              end
            end
          end
        end
`endif
        default: begin
          // ERROR: hold until reset, nothing forwarded.
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inpkt_parser.sv
// Testbench for inpkt_parser: FIFO model feeding a byte queue, scoreboard of
// expected payload bytes, per-scenario tasks. Honors INPKT_CKSUM_EN.
module tb_inpkt_parser;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        empty = 1'b1;
  logic        rd_en;
  logic        hdr_valid;
  logic [7:0]  pkt_type;
  logic [15:0] pkt_id;
  logic [23:0] pkt_len;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        dout_last;
  logic        pkt_done;
  logic [7:0]  status;

  inpkt_parser dut (
    .CLK(CLK), .RESET_N(RESET_N), .din(din), .empty(empty), .rd_en(rd_en),
    .hdr_valid(hdr_valid), .pkt_type(pkt_type), .pkt_id(pkt_id), .pkt_len(pkt_len),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .pkt_done(pkt_done), .status(status)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Stream bytes: {is_payload, byte}. Scoreboard: {last, byte}.
  logic [8:0]  strm[$];
  logic [8:0]  sb[$];
  logic [15:0] model_sum;
  bit          ready_toggle = 0;
  bit          rand_empty = 0;
  int          hdr_cnt = 0;
  int          done_cnt = 0;
  int          last_cnt = 0;
  logic [7:0]  got_type;
  logic [15:0] got_id;
  logic [23:0] got_len;

  // FIFO model / output sink / monitor: drive at negedge, sample 1 ns later.
  initial begin
    logic [8:0] exp;
    forever begin
      @(negedge CLK);
      empty = (strm.size() == 0) || (rand_empty && ($urandom_range(0, 2) == 0));
      din = (strm.size() != 0) ? strm[0][7:0] : 8'h00;
      dout_ready = ready_toggle ? ~dout_ready : 1'b1;
      #1;
      if (RESET_N) begin
        if (hdr_valid) begin
          hdr_cnt++;
          got_type = pkt_type;
          got_id = pkt_id;
          got_len = pkt_len;
        end
        if (rd_en && !empty && strm.size() != 0) begin
          if (strm[0][8]) begin
            checks++;
            if (dout_valid && !dout_ready) begin
              failures++;
              $display("FAIL rd_while_stalled got rd_en=1 exp rd_en=0 at %0t", $time);
            end
          end
          void'(strm.pop_front());
        end
        if (dout_valid && dout_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL dout_extra got %h exp none", {dout_last, dout});
          end else begin
            exp = sb.pop_front();
            if ({dout_last, dout} !== exp) begin
              failures++;
              $display("FAIL dout got last=%b byte=%h exp last=%b byte=%h", dout_last, dout, exp[8], exp[7:0]);
            end
            if (exp[8]) last_cnt++;
          end
        end
        if (pkt_done) begin
          done_cnt++;
          checks++;
          if (done_cnt > last_cnt) begin
            failures++;
            $display("FAIL pkt_done_early got done=%0d exp <= lasts=%0d", done_cnt, last_cnt);
          end
        end
      end
    end
  end

  task automatic push_hdr(input logic [7:0] ver, input logic [7:0] typ,
                          input logic [15:0] id, input logic [23:0] len,
                          input logic [7:0] b7);
    logic [7:0] h[8];
    h = '{ver, typ, id[7:0], id[15:8], len[7:0], len[15:8], len[23:16], b7};
    model_sum = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      strm.push_back({1'b0, h[i]});
      model_sum += {8'h00, h[i]};
    end
  endtask

  task automatic push_body(input int len, input logic [7:0] base,
                           input logic [7:0] step, input logic [15:0] ck_delta);
    logic [7:0]  b;
    logic [15:0] ck;
    b = base;
    for (int i = 0; i < len; i++) begin
      strm.push_back({1'b1, b});
      sb.push_back({(i == len - 1), b});
      model_sum += {8'h00, b};
      b += step;
    end
    ck = model_sum + ck_delta;
`ifdef INPKT_CKSUM_EN
    strm.push_back({1'b0, ck[7:0]});
    strm.push_back({1'b0, ck[15:8]});
`endif
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    strm.delete();
    sb.delete();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic wait_drain(input int max, input string name);
    int n = 0;
    while ((strm.size() != 0 || sb.size() != 0) && n < max) begin
      @(negedge CLK);
      n++;
    end
    repeat (4) @(negedge CLK);
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s_timeout got %0d cycles exp < %0d", name, n, max);
    end
  endtask

  task automatic test_reset();
    #1 RESET_N = 1'b0;
    @(negedge CLK);
    strm.push_back(9'h002);
    strm.push_back(9'h001);
    @(negedge CLK);
    #2;
    checks++;
    if (rd_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_rd_en got %b exp 0", rd_en);
    end
    checks++;
    if ({hdr_valid, pkt_type, pkt_id, pkt_len, dout, dout_valid, dout_last, pkt_done, status} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got type=%h id=%h len=%h dout=%h st=%h exp all 0", pkt_type, pkt_id, pkt_len, dout, status);
    end
    strm.delete();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic run_good(input string name, input logic [7:0] typ, input logic [15:0] id,
                          input int len, input logic [7:0] base, input logic [7:0] step, input int max);
    int h0 = hdr_cnt;
    int d0 = done_cnt;
    push_hdr(8'd2, typ, id, len[23:0], 8'h00);
    push_body(len, base, step, 16'h0000);
    wait_drain(max, name);
    checks++;
    if (hdr_cnt !== h0 + 1 || got_type !== typ || got_id !== id || got_len !== len[23:0]) begin
      failures++;
      $display("FAIL %s_hdr got n=%0d type=%h id=%h len=%h exp n=%0d type=%h id=%h len=%h",
               name, hdr_cnt - h0, got_type, got_id, got_len, 1, typ, id, len[23:0]);
    end
    checks++;
    if (done_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL %s_done got %0d exp 1", name, done_cnt - d0);
    end
    checks++;
    if (status !== 8'h00) begin
      failures++;
      $display("FAIL %s_status got %h exp 00", name, status);
    end
  endtask

  task automatic test_basic();
    run_good("basic", 8'h01, 16'h1234, 3, 8'hAA, 8'h11, 200);
  endtask

  task automatic test_stall();
    ready_toggle = 1;
    rand_empty = 1;
    run_good("stall", 8'h01, 16'h1234, 3, 8'hAA, 8'h11, 500);
    run_good("stall2", 8'h02, 16'hBEEF, 9, 8'h01, 8'h07, 800);
    ready_toggle = 0;
    rand_empty = 0;
    @(negedge CLK);
  endtask

  task automatic test_hdr_err(input string name, input logic [7:0] ver, input logic [7:0] typ,
                              input logic [23:0] len, input logic [7:0] b7, input logic [7:0] exp_st);
    int h0;
    do_reset();
    h0 = hdr_cnt;
    push_hdr(ver, typ, 16'h5555, len, b7);
    for (int i = 0; i < 4; i++) strm.push_back(9'h0EE);
    repeat (20) @(negedge CLK);
    #2;
    checks++;
    if (status !== exp_st) begin
      failures++;
      $display("FAIL %s_status got %h exp %h", name, status, exp_st);
    end
    checks++;
    if (rd_en !== 1'b0 || strm.size() != 4 || hdr_cnt != h0) begin
      failures++;
      $display("FAIL %s_halt got rd_en=%b left=%0d hdrs=%0d exp rd_en=0 left=4 hdrs=0", name, rd_en, strm.size(), hdr_cnt - h0);
    end
  endtask

  task automatic test_errors();
    test_hdr_err("version", 8'd3, 8'd1, 24'd3, 8'h00, 8'h01);
    do_reset();
    #2;
    checks++;
    if (status !== 8'h00) begin
      failures++;
      $display("FAIL version_clear got %h exp 00", status);
    end
    run_good("after_reset", 8'h01, 16'h0042, 3, 8'hAA, 8'h11, 200);
    test_hdr_err("type0", 8'd2, 8'd0, 24'd3, 8'h00, 8'h02);
    test_hdr_err("type9", 8'd2, 8'd9, 24'd3, 8'h00, 8'h02);
    test_hdr_err("len0", 8'd2, 8'd1, 24'd0, 8'h00, 8'h04);
    test_hdr_err("len16385", 8'd2, 8'd1, 24'd16385, 8'h00, 8'h04);
    test_hdr_err("byte7", 8'd2, 8'd2, 24'd3, 8'h01, 8'h04);
    test_hdr_err("multi", 8'd7, 8'd0, 24'd0, 8'h00, 8'h07);
    do_reset();
  endtask

  task automatic test_maxlen();
    run_good("maxlen", 8'h02, 16'h0001, 16384, 8'h00, 8'h01, 20000);
  endtask

  task automatic test_cksum();
`ifdef INPKT_CKSUM_EN
    int d0 = done_cnt;
    push_hdr(8'd2, 8'd1, 16'h1234, 24'd3, 8'h00);
    push_body(3, 8'hAA, 8'h11, 16'h0001);
    wait_drain(200, "cksum_err");
    checks++;
    if (status !== 8'h08 || done_cnt !== d0) begin
      failures++;
      $display("FAIL cksum_err got status=%h done=%0d exp status=08 done=0", status, done_cnt - d0);
    end
    do_reset();
`else
    run_good("nocksum", 8'h01, 16'h1234, 3, 8'hAA, 8'h11, 200);
`endif
  endtask

  task automatic test_back_to_back();
    int h0 = hdr_cnt;
    int d0 = done_cnt;
    int n = 0;
    push_hdr(8'd2, 8'd1, 16'h0A0A, 24'd3, 8'h00);
    push_body(3, 8'hAA, 8'h11, 16'h0000);
    push_hdr(8'd2, 8'd2, 16'hB0B0, 24'd8, 8'h00);
    push_body(8, 8'h10, 8'h01, 16'h0000);
    while (!(done_cnt > d0 && hdr_cnt >= h0 + 2 && sb.size() < 6) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= 300 || done_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL b2b_first got done=%0d cycles=%0d exp done=1", done_cnt - d0, n);
    end
    RESET_N = 1'b0;
    strm.delete();
    sb.delete();
    #2;
    checks++;
    if ({rd_en, hdr_valid, pkt_type, pkt_id, pkt_len, dout, dout_valid, dout_last, pkt_done, status} !== '0) begin
      failures++;
      $display("FAIL b2b_reset got rd=%b dv=%b type=%h id=%h len=%h dout=%h exp all 0", rd_en, dout_valid, pkt_type, pkt_id, pkt_len, dout);
    end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    run_good("b2b_resend", 8'h02, 16'hB0B0, 8, 8'h10, 8'h01, 300);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_errors();
    test_maxlen();
    test_cksum();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
